gpio_multi: RTL and testbench

GPIO_MULTI -- requirements
Module: gpio_multi

---
 rtl/gpio_multi_if.sv | 11 +
 rtl/gpio_multi.sv | 123 ++++++++++++
 tb/tb_gpio_multi.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_multi_if.sv
// Register-bus bundle for gpio_multi: 5-bit {port,reg} address, 8-bit data, one-cycle strobes.
interface gpio_multi_if;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       wr;
  logic       rd;
  logic [7:0] rdata;

  modport master (output addr, output wdata, output wr, output rd, input rdata);
  modport slave  (input addr, input wdata, input wr, input rd, output rdata);
endinterface

// File: rtl/gpio_multi.sv
// Multi-port GPIO: OUT/DIR/IN/IE/IF per port, synchronised inputs, sticky edge flags, level irq.
// Define GPIO_MULTI_FALLEDGE_EN to add the per-pin EDGE register (falling-edge select) at reg 5.
module gpio_multi #(
  parameter int NPORTS      = 3,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  gpio_multi_if.slave               bus,
  input  logic [NPORTS*WIDTH-1:0]   pin_in,
  output logic [NPORTS*WIDTH-1:0]   pin_out,
  output logic [NPORTS*WIDTH-1:0]   pin_oe,
  output logic                      irq
);

  logic [1:0]       port_idx;
  logic [2:0]       reg_idx;
  logic [WIDTH-1:0] wbits;
  logic [7:0]       port_rd [4];
  logic [3:0]       port_irq;
  logic             unused_wdata;

  assign port_idx     = bus.addr[4:3];
  assign reg_idx      = bus.addr[2:0];
  assign wbits        = bus.wdata[WIDTH-1:0];
  assign unused_wdata = ^bus.wdata;

  // Address space always has four port slots; slots beyond NPORTS read 0 and ignore writes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port
      if (gi < NPORTS) begin : g_on
        logic [WIDTH-1:0] out_reg, dir_reg, ie_reg, if_reg, hist_reg;
        logic [WIDTH-1:0] in_val, edge_det, if_next, clr_mask;
        logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
        logic [7:0] rd_val;
        logic       sel;

        assign sel    = bus.wr && (port_idx == 2'(gi));
        assign in_val = sync_reg[SYNC_STAGES-1];

`ifdef GPIO_MULTI_FALLEDGE_EN
        logic [WIDTH-1:0] edge_reg;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            edge_reg <= '0;
          end else if (sel && reg_idx == 3'd5) begin
            edge_reg <= wbits;
          end
        end

        assign edge_det = (in_val & ~hist_reg & ~edge_reg) | (~in_val & hist_reg & edge_reg);
`else
        assign edge_det = in_val & ~hist_reg;
`endif

        // A fresh edge overrides a same-cycle write-1-to-clear.
        assign clr_mask = (sel && reg_idx == 3'd4) ? wbits : '0;
        assign if_next  = (if_reg & ~clr_mask) | edge_det;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            out_reg  <= '0;
            dir_reg  <= '0;
            ie_reg   <= '0;
            if_reg   <= '0;
            hist_reg <= '0;
            sync_reg <= '0;
          end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin_in[gi*WIDTH +: WIDTH]};
            hist_reg <= in_val;
            if_reg   <= if_next;
            if (sel) begin
              case (reg_idx)
                3'd0:    out_reg <= wbits;
                3'd1:    dir_reg <= wbits;
                3'd3:    ie_reg  <= wbits;
                default: ;
              endcase
            end
          end
        end

        always_comb begin
          rd_val = '0;
          case (reg_idx)
            3'd0:    rd_val = 8'(out_reg);
            3'd1:    rd_val = 8'(dir_reg);
            3'd2:    rd_val = 8'(in_val);
            3'd3:    rd_val = 8'(ie_reg);
            3'd4:    rd_val = 8'(if_reg);
`ifdef GPIO_MULTI_FALLEDGE_EN
            3'd5:    rd_val = 8'(edge_reg);
`endif
            default: rd_val = '0;
          endcase
        end

        assign port_rd[gi]                 = rd_val;
        assign port_irq[gi]                = |(if_reg & ie_reg);
        assign pin_out[gi*WIDTH +: WIDTH]  = out_reg;
        assign pin_oe[gi*WIDTH +: WIDTH]   = dir_reg;
      end else begin : g_off
        assign port_rd[gi]  = '0;
        assign port_irq[gi] = 1'b0;
      end
    end
  endgenerate

  // Registers update on the same edge, so a simultaneous write is not yet visible here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rdata <= '0;
    end else if (bus.rd) begin
      bus.rdata <= port_rd[port_idx];
    end
  end

  assign irq = |port_irq;

endmodule

// File: tb/tb_gpio_multi.sv
// Self-checking bench for gpio_multi: directed scenarios then random bus/pad traffic vs. a sample-history model.
module tb_gpio_multi;
  localparam int NP  = 3;
  localparam int W   = 8;
  localparam int S   = 2;
  localparam int NPW = NP * W;

  logic           clk = 1'b0;
  logic           reset;
  logic [NPW-1:0] pin_in, pin_out, pin_oe;
  logic           irq;

  gpio_multi_if bus ();

  gpio_multi #(.NPORTS(NP), .WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: register contents plus pad values sampled at recent edges (samp[j] = j edges ago).
  logic [W-1:0]   m_out [NP], m_dir [NP], m_ie [NP], m_if [NP], m_edge [NP];
  logic [7:0]     m_rdata;
  logic [NPW-1:0] samp [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] a_of(input int p, input int r);
    return {2'(p), 3'(r)};
  endfunction

  task automatic m_reset();
    for (int q = 0; q < NP; q++) begin
      m_out[q] = '0; m_dir[q] = '0; m_ie[q] = '0; m_if[q] = '0; m_edge[q] = '0;
    end
    for (int j = 0; j < 4; j++) samp[j] = '0;
    m_rdata = '0;
  endtask

  // IN is the pad value captured S-1 edges before the current one.
  function automatic logic [7:0] m_read(input int p, input int r);
    logic [7:0] v;
    v = '0;
    if (p < NP) begin
      case (r)
        0: v = 8'(m_out[p]);
        1: v = 8'(m_dir[p]);
        2: v = 8'(samp[S-1][p*W +: W]);
        3: v = 8'(m_ie[p]);
        4: v = 8'(m_if[p]);
`ifdef GPIO_MULTI_FALLEDGE_EN
        5: v = 8'(m_edge[p]);
`endif
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  function automatic logic m_irq();
    logic v;
    v = 1'b0;
    for (int q = 0; q < NP; q++) v = v | (|(m_if[q] & m_ie[q]));
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic m_step();
    int p, r;
    logic [7:0] rv;
    logic [W-1:0] nin, nh, ev, clr;
    p  = int'(bus.addr[4:3]);
    r  = int'(bus.addr[2:0]);
    rv = m_read(p, r);
    for (int q = 0; q < NP; q++) begin
      nin = samp[S-1][q*W +: W];
      nh  = samp[S][q*W +: W];
      ev  = (nin & ~nh & ~m_edge[q]) | (~nin & nh & m_edge[q]);
      clr = (bus.wr && p == q && r == 4) ? bus.wdata[W-1:0] : '0;
      m_if[q] = (m_if[q] & ~clr) | ev;
    end
    if (bus.wr && p < NP) begin
      case (r)
        0: m_out[p] = bus.wdata[W-1:0];
        1: m_dir[p] = bus.wdata[W-1:0];
        3: m_ie[p]  = bus.wdata[W-1:0];
`ifdef GPIO_MULTI_FALLEDGE_EN
        5: m_edge[p] = bus.wdata[W-1:0];
`endif
        default: ;
      endcase
    end
    if (bus.rd) m_rdata = rv;
    for (int j = 3; j > 0; j--) samp[j] = samp[j-1];
    samp[0] = pin_in;
  endtask

  task automatic check_outputs();
    logic [NPW-1:0] eo, ee;
    for (int q = 0; q < NP; q++) begin
      eo[q*W +: W] = m_out[q];
      ee[q*W +: W] = m_dir[q];
    end
    chk("pin_out", 32'(pin_out), 32'(eo));
    chk("pin_oe", 32'(pin_oe), 32'(ee));
    chk("irq", 32'(irq), 32'(m_irq()));
    chk("rdata", 32'(bus.rdata), 32'(m_rdata));
  endtask

  task automatic cycle(input logic w, input logic r, input logic [4:0] a, input logic [7:0] d);
    bus.wr = w; bus.rd = r; bus.addr = a; bus.wdata = d;
    m_step();
    @(posedge clk);
    #1;
    check_outputs();
    bus.wr = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  initial begin
    pin_in = '0; bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.wdata = '0;
    reset = 1'b0;
    m_reset();
    #1 reset = 1'b1;
    #1;
    chk("reset_pin_oe", 32'(pin_oe), 32'd0);
    chk("reset_pin_out", 32'(pin_out), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_rdata", 32'(bus.rdata), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Port 1 output drive and readback
    cycle(1'b1, 1'b0, a_of(1, 1), 8'hFF);
    chk("s1_oe", 32'(pin_oe[15:8]), 32'hFF);
    cycle(1'b1, 1'b0, a_of(1, 0), 8'hA5);
    chk("s1_out", 32'(pin_out[15:8]), 32'hA5);
    cycle(1'b0, 1'b1, a_of(1, 0), 8'h00);
    chk("s1_rd_out", 32'(bus.rdata), 32'hA5);
    cycle(1'b0, 1'b1, a_of(1, 1), 8'h00);
    chk("s1_rd_dir", 32'(bus.rdata), 32'hFF);
    cycle(1'b1, 1'b1, a_of(1, 0), 8'h3C);
    chk("rd_wr_same_cycle", 32'(bus.rdata), 32'hA5);

    // Unimplemented port slot and unused registers
    cycle(1'b1, 1'b0, a_of(3, 0), 8'hFF);
    cycle(1'b0, 1'b1, a_of(3, 0), 8'h00);
    chk("bad_port_rd", 32'(bus.rdata), 32'h00);
    cycle(1'b1, 1'b0, a_of(0, 6), 8'hFF);
    cycle(1'b0, 1'b1, a_of(0, 6), 8'h00);
    chk("reg6_rd", 32'(bus.rdata), 32'h00);

    // Rising edge on pin 0: IN after S edges, IF one edge later
    pin_in[0] = 1'b1;
    idle(S);
    cycle(1'b0, 1'b1, a_of(0, 2), 8'h00);
    chk("s2_in", 32'(bus.rdata), 32'h01);
    cycle(1'b0, 1'b1, a_of(0, 4), 8'h00);
    chk("s2_if", 32'(bus.rdata), 32'h01);
    chk("s2_irq_off", 32'(irq), 32'd0);
    cycle(1'b1, 1'b0, a_of(0, 3), 8'h01);
    chk("s2_irq_on", 32'(irq), 32'd1);
    cycle(1'b1, 1'b0, a_of(0, 3), 8'h00);

    // Port 2 IF=0x03 then partial W1C
    pin_in[17:16] = 2'b11;
    idle(S + 2);
    cycle(1'b1, 1'b0, a_of(2, 3), 8'h02);
    cycle(1'b1, 1'b0, a_of(2, 4), 8'h01);
    cycle(1'b0, 1'b1, a_of(2, 4), 8'h00);
    chk("s3_if", 32'(bus.rdata), 32'h02);
    chk("s3_irq", 32'(irq), 32'd1);

    // Edge on pin 16 coincides with W1C of the same bit
    pin_in[16] = 1'b0;
    idle(S + 1);
    pin_in[16] = 1'b1;
    idle(S);
    cycle(1'b1, 1'b0, a_of(2, 4), 8'h01);
    cycle(1'b0, 1'b1, a_of(2, 4), 8'h00);
    chk("s4_if_set_wins", 32'(bus.rdata), 32'h03);
    cycle(1'b1, 1'b0, a_of(2, 4), 8'h01);
    cycle(1'b0, 1'b1, a_of(2, 4), 8'h00);
    chk("s4_if_clear", 32'(bus.rdata), 32'h02);

    // Asynchronous reset mid-write
    cycle(1'b1, 1'b0, a_of(0, 1), 8'hFF);
    cycle(1'b1, 1'b0, a_of(0, 3), 8'hFF);
    cycle(1'b0, 1'b1, a_of(0, 1), 8'h00);
    bus.wr = 1'b1; bus.addr = a_of(0, 0); bus.wdata = 8'hFF;
    #2 reset = 1'b1;
    #1;
    chk("s5_pin_oe", 32'(pin_oe), 32'd0);
    chk("s5_pin_out", 32'(pin_out), 32'd0);
    chk("s5_irq", 32'(irq), 32'd0);
    chk("s5_rdata", 32'(bus.rdata), 32'd0);
    bus.wr = 1'b0;
    m_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    check_outputs();

    // Pads held high through release set IF S+1 edges later
    idle(S);
    cycle(1'b0, 1'b1, a_of(2, 4), 8'h00);
    chk("rel_if_early", 32'(bus.rdata), 32'h00);
    cycle(1'b0, 1'b1, a_of(2, 4), 8'h00);
    chk("rel_if_set", 32'(bus.rdata), 32'h03);
    chk("rel_irq", 32'(irq), 32'd0);

`ifdef GPIO_MULTI_FALLEDGE_EN
    cycle(1'b1, 1'b0, a_of(0, 5), 8'h01);
    cycle(1'b1, 1'b0, a_of(0, 4), 8'hFF);
    cycle(1'b0, 1'b1, a_of(0, 4), 8'h00);
    chk("s6_if_clean", 32'(bus.rdata), 32'h00);
    pin_in[0] = 1'b0;
    idle(S + 1);
    cycle(1'b0, 1'b1, a_of(0, 4), 8'h00);
    chk("s6_fall_set", 32'(bus.rdata & 8'h01), 32'h01);
    cycle(1'b1, 1'b0, a_of(0, 4), 8'h01);
    pin_in[0] = 1'b1;
    idle(S + 2);
    cycle(1'b0, 1'b1, a_of(0, 4), 8'h00);
    chk("s6_rise_ignored", 32'(bus.rdata & 8'h01), 32'h00);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) pin_in = NPW'($urandom);
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            5'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
